// File: rtl/bcd_timer_core.sv
// bcd_timer_core
//   Shared multi-digit BCD up/down counting engine for the clock, countdown
//   timer and stopwatch panels. An internal prescaler turns TICK_DIV clock
//   cycles into one count step; the count either wraps or stops at the
//   terminal value for the current direction, and a one-cycle done pulse
//   marks every terminal event.
//
//   Optional feature macro: LAP_CAPTURE_EN
//     defined     - lap register present, lap_capture snapshots count
//     not defined - lap_value tied to 0, lap_capture ignored
//
// Parameters
//   DIGITS     number of BCD digits (digit 0 least significant)
//   DIGIT_MOD  packed 4-bit modulus per digit, digit i at [4i+3:4i], 2..10
//   TICK_DIV   clk cycles per count step, >= 1
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        pulse: enable counting
//   stop         pulse: pause counting (prescaler keeps its phase)
//   clr          synchronous clear of count, prescaler and lap value
//   ld           synchronous load of load_data (illegal digits become 0)
//   load_data    BCD load value
//   dir          0 = count up, 1 = count down (sampled at each tick)
//   wrap_en      1 = wrap at terminal, 0 = stop at terminal
//   lap_capture  pulse: snapshot the count
//   count        current BCD value
//   running      counting enabled
//   done         one-cycle terminal-count pulse
//   lap_value    last captured count
module bcd_timer_core #(
  parameter int                  DIGITS    = 4,
  parameter logic [4*DIGITS-1:0] DIGIT_MOD = {4'd6, 4'd10, 4'd6, 4'd10},
  parameter int                  TICK_DIV  = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                clr,
  input  logic                ld,
  input  logic [4*DIGITS-1:0] load_data,
  input  logic                dir,
  input  logic                wrap_en,
  input  logic                lap_capture,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                done,
  output logic [4*DIGITS-1:0] lap_value
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Largest legal value of digit i.
  function automatic logic [3:0] digit_max(input int i);
    return DIGIT_MOD[4*i +: 4] - 4'd1;
  endfunction

  // Replace every out-of-range digit by 0, each digit independently.
  function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > digit_max(i)) r[4*i +: 4] = 4'd0;
    end
    return r;
  endfunction

  // One count step with ripple carry/borrow across all digits.
  // The MSB of the result is the carry (or borrow) out of the top digit,
  // i.e. it is set exactly when the step wraps around the full range.
  function automatic logic [W:0] step(input logic [W-1:0] v, input logic down);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    logic [3:0]   m;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      m = digit_max(i);
      if (c) begin
        if (!down) begin
          if (d >= m) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*i +: 4] = m;
          end else begin
            r[4*i +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return {c, r};
  endfunction

  logic [W-1:0]  r_count;
  logic          r_running;
  logic          r_done;
  logic [PW-1:0] r_presc;

  logic [W-1:0]  w_all_max;
  logic [W:0]    w_step;
  logic [W-1:0]  w_next;
  logic          w_wrap_out;
  logic          w_tick;
  logic          w_at_term;
  logic          w_next_term;

  always_comb begin
    w_all_max = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_all_max[4*i +: 4] = digit_max(i);
    end
  end

  always_comb begin
    w_step      = step(r_count, dir);
    w_next      = w_step[W-1:0];
    w_wrap_out  = w_step[W];
    // Terminal value depends on direction: all-max going up, all-zero down.
    w_at_term   = dir ? (r_count == '0) : (r_count == w_all_max);
    w_next_term = dir ? (w_next  == '0) : (w_next  == w_all_max);
    w_tick      = r_running && (r_presc == PRESC_LAST);
  end

  // Control chain: clr > ld > stop > start > tick. Only the highest-priority
  // action present on an edge takes effect; the prescaler advances only on
  // edges where none of the control pulses is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_presc   <= '0;
    end else begin
      r_done <= 1'b0;
      if (clr) begin
        r_count <= '0;
        r_presc <= '0;
      end else if (ld) begin
        r_count <= sanitize(load_data);
        r_presc <= '0;
      end else if (stop) begin
        r_running <= 1'b0;
      end else if (start) begin
        // In stop-at-terminal mode there is nothing left to count.
        if (wrap_en || !w_at_term) r_running <= 1'b1;
      end else if (r_running) begin
        if (w_tick) begin
          r_presc <= '0;
          if (wrap_en) begin
            r_count <= w_next;
            r_done  <= w_wrap_out;
          end else if (w_at_term) begin
            // Already parked on the terminal (e.g. loaded there while
            // running): hold the value and pause.
            r_running <= 1'b0;
          end else begin
            r_count <= w_next;
            if (w_next_term) begin
              r_done    <= 1'b1;
              r_running <= 1'b0;
            end
          end
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

`ifdef LAP_CAPTURE_EN
  logic [W-1:0] r_lap;

  // Snapshot is the value held before this edge's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lap <= '0;
    end else if (clr) begin
      r_lap <= '0;
    end else if (lap_capture) begin
      r_lap <= r_count;
    end
  end

  assign lap_value = r_lap;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap_capture;
  assign lap_value    = '0;
`endif

  assign count   = r_count;
  assign running = r_running;
  assign done    = r_done;

endmodule

// File: tb/tb_bcd_timer_core.sv
module tb_bcd_timer_core;

  localparam int TD = 4;
  localparam int N  = 3600;
  localparam int MODS [4] = '{10, 6, 10, 6};

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, stop, clr, ld, dir, wrap_en, lap_capture;
  logic [15:0] load_data, count, lap_value;
  logic        running, done;

  bcd_timer_core #(
    .DIGITS   (4),
    .DIGIT_MOD({4'd6, 4'd10, 4'd6, 4'd10}),
    .TICK_DIV (TD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .clr        (clr),
    .ld         (ld),
    .load_data  (load_data),
    .dir        (dir),
    .wrap_en    (wrap_en),
    .lap_capture(lap_capture),
    .count      (count),
    .running    (running),
    .done       (done),
    .lap_value  (lap_value)
  );

  typedef struct packed {
    logic [15:0] c;
    logic        r;
    logic        d;
    logic [15:0] l;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: count held as a plain integer 0..N-1 in mixed radix.
  int          m_val;
  int          m_presc;
  bit          m_run;
  bit          m_done;
  logic [15:0] m_lap;
  logic        s_dir;
  logic        s_wrap;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % MODS[i]);
      t = t / MODS[i];
    end
    return r;
  endfunction

  function automatic int load_val(input logic [15:0] b);
    int v, w, d;
    v = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(b[4*i +: 4]);
      if (d >= MODS[i]) d = 0;
      v = v + d * w;
      w = w * MODS[i];
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.c = to_bcd(m_val);
    e.r = m_run;
    e.d = m_done;
    e.l = m_lap;
    q.push_back(e);
  endtask

  task automatic model_step(input bit st, input bit sp, input bit cl, input bit l,
                            input logic [15:0] data, input bit lc);
    logic [15:0] old;
    int          term;
    old    = to_bcd(m_val);
    term   = s_dir ? 0 : N - 1;
    m_done = 0;
    if (cl) begin
      m_val   = 0;
      m_presc = 0;
    end else if (l) begin
      m_val   = load_val(data);
      m_presc = 0;
    end else if (sp) begin
      m_run = 0;
    end else if (st) begin
      if (s_wrap || m_val != term) m_run = 1;
    end else if (m_run) begin
      if (m_presc == TD - 1) begin
        m_presc = 0;
        if (m_val == term) begin
          if (s_wrap) begin
            m_val  = s_dir ? N - 1 : 0;
            m_done = 1;
          end else begin
            m_run = 0;
          end
        end else begin
          m_val = s_dir ? m_val - 1 : m_val + 1;
          if (!s_wrap && m_val == term) begin
            m_done = 1;
            m_run  = 0;
          end
        end
      end else begin
        m_presc++;
      end
    end
`ifdef LAP_CAPTURE_EN
    if (cl) m_lap = '0;
    else if (lc) m_lap = old;
`else
    if (lc) m_lap = '0;
`endif
    push_exp();
  endtask

  task automatic cycle(input bit st, input bit sp, input bit cl, input bit l,
                       input logic [15:0] data, input bit lc);
    @(negedge clk);
    rst_n       = 1'b1;
    start       = st;
    stop        = sp;
    clr         = cl;
    ld          = l;
    load_data   = data;
    lap_capture = lc;
    dir         = s_dir;
    wrap_en     = s_wrap;
    model_step(st, sp, cl, l, data, lc);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 16'h0000, 0);
  endtask

  // Asynchronous reset in the middle of a clock period: outputs must clear
  // before the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 0; stop = 0; clr = 0; ld = 0; lap_capture = 0;
    #1;
    chk("rst_count",   count,              16'h0000);
    chk("rst_running", {15'd0, running},   16'h0000);
    chk("rst_done",    {15'd0, done},      16'h0000);
    chk("rst_lap",     lap_value,          16'h0000);
    m_val = 0; m_presc = 0; m_run = 0; m_done = 0; m_lap = '0;
    push_exp();
  endtask

  // Monitor: one expected entry per rising edge, compared just after it.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count",   count,            e.c);
        chk("running", {15'd0, running}, {15'd0, e.r});
        chk("done",    {15'd0, done},    {15'd0, e.d});
        chk("lap",     lap_value,        e.l);
      end
    end
  end

  logic [15:0] tbl [6];

  initial begin
    bit          st, sp, cl, l, lc;
    logic [15:0] data;
    int          r;

    tbl = '{16'h5958, 16'h5959, 16'h0000, 16'h0001, 16'h0958, 16'h0100};
    rst_n = 1'b0; start = 0; stop = 0; clr = 0; ld = 0; load_data = '0;
    dir = 0; wrap_en = 0; lap_capture = 0;
    s_dir = 0; s_wrap = 0;
    m_val = 0; m_presc = 0; m_run = 0; m_done = 0; m_lap = '0;
    #2;
    chk("init_count",   count,            16'h0000);
    chk("init_running", {15'd0, running}, 16'h0000);
    chk("init_done",    {15'd0, done},    16'h0000);
    chk("init_lap",     lap_value,        16'h0000);

    // Up to terminal without wrap, then a start that must be ignored.
    s_dir = 0; s_wrap = 0;
    cycle(0, 0, 0, 1, 16'h5958, 0);
    cycle(1, 0, 0, 0, 16'h0000, 0);
    idle(6);
    cycle(1, 0, 0, 0, 16'h0000, 0);
    idle(3);

    // Down to zero, then a borrow across digits.
    s_dir = 1;
    cycle(0, 0, 0, 1, 16'h0001, 0);
    cycle(1, 0, 0, 0, 16'h0000, 0);
    idle(5);
    cycle(0, 0, 0, 1, 16'h0100, 0);
    cycle(1, 0, 0, 0, 16'h0000, 0);
    idle(5);
    cycle(0, 1, 0, 0, 16'h0000, 0);

    // Wrap up from all-max, then wrap down from zero.
    s_dir = 0; s_wrap = 1;
    cycle(0, 0, 0, 1, 16'h5959, 0);
    cycle(1, 0, 0, 0, 16'h0000, 0);
    idle(5);
    s_dir = 1;
    idle(5);
    cycle(0, 1, 0, 0, 16'h0000, 0);

    // Illegal digits on load, start and stop together.
    cycle(0, 0, 0, 1, 16'hA7F3, 0);
    cycle(1, 1, 0, 0, 16'h0000, 0);
    idle(2);

    // Pause keeps the prescaler phase; clr while running keeps running.
    s_dir = 0; s_wrap = 1;
    cycle(0, 0, 0, 1, 16'h0000, 0);
    cycle(1, 0, 0, 0, 16'h0000, 0);
    idle(2);
    cycle(0, 1, 0, 0, 16'h0000, 0);
    idle(10);
    cycle(1, 0, 0, 0, 16'h0000, 0);
    idle(4);
    cycle(0, 0, 1, 0, 16'h0000, 0);
    idle(3);

    // Lap capture on a tick edge, then asynchronous reset mid-run.
    cycle(0, 0, 0, 1, 16'h0012, 0);
    cycle(1, 0, 0, 0, 16'h0000, 0);
    idle(3);
    cycle(0, 0, 0, 0, 16'h0000, 1);
    idle(2);
    do_reset();
    idle(2);

    // Randomised traffic biased towards the terminal values.
    for (int k = 0; k < 2500; k++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 29) == 0) s_dir  = ~s_dir;
        if ($urandom_range(0, 29) == 0) s_wrap = ~s_wrap;
        st = ($urandom_range(0, 9)  == 0);
        sp = ($urandom_range(0, 24) == 0);
        cl = ($urandom_range(0, 59) == 0);
        l  = ($urandom_range(0, 29) == 0);
        lc = ($urandom_range(0, 9)  == 0);
        if ($urandom_range(0, 1) == 0) data = tbl[$urandom_range(0, 5)];
        else data = 16'($urandom);
        cycle(st, sp, cl, l, data, lc);
      end
    end

    idle(2);
    repeat (5) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_timer_core.md
# bcd_timer_core

Parametrised multi-digit BCD up/down timer core with an internal tick prescaler, terminal-count detection, wrap/saturate selection and optional lap capture. It replaces the fixed four-digit timer/stopwatch datapath as the shared counting engine for the clock, countdown-timer and stopwatch front panels. It sits between the control FSM (start/stop/clr/ld pulses) and the seven-segment display driver (count bus).

## Interface
- DIGITS, 4: number of BCD digits; digit 0 is least significant.
- DIGIT_MOD, {4'd6,4'd10,4'd6,4'd10}: packed 4 bits per digit, digit i at [4i+3:4i]; modulus of digit i, legal 2..10.
- TICK_DIV, 1_000_000: clk cycles per count step; legal >= 1.

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  pulse: set running
- stop  in  1  pulse: clear running (pause)
- clr  in  1  synchronous clear of count, prescaler, lap_value
- ld  in  1  synchronous load of load_data
- load_data  in  4*DIGITS  BCD load value
- dir  in  1  0 = count up, 1 = count down
- wrap_en  in  1  1 = wrap at terminal, 0 = stop at terminal
- lap_capture  in  1  pulse: snapshot count
- count  out  4*DIGITS  current BCD value
- running  out  1  counting enabled
- done  out  1  one-cycle terminal-count pulse
- lap_value  out  4*DIGITS  last captured count

## Operation
- Reset values: count 0, running 0, done 0, lap_value 0, prescaler 0.
- Priority per edge: clr > ld > stop > start > tick. start and stop together: running <= 0.
- clr: count <= 0, prescaler <= 0, lap_value <= 0; running unchanged.
- ld: digit i <= load_data digit i if <= DIGIT_MOD[i]-1, else 0 (per digit, independent); prescaler <= 0; running unchanged.
- stop: running <= 0; prescaler holds (resume continues the partial period).
- start: running <= 1, except when wrap_en = 0 and count already equals the terminal for dir (all-max for up, all-zero for down): start ignored.
- Prescaler: counts 0..TICK_DIV-1 only while running; at TICK_DIV-1 it returns to 0 and issues one tick.
- Tick, up: digit 0 increments; digit at max rolls to 0 and carries to next digit; carry ripples in the same cycle.
- Tick, down: digit 0 decrements; digit at 0 becomes DIGIT_MOD[i]-1 and borrows.
- Terminal, wrap_en = 0: tick producing all-max (up) or all-zero (down) updates count, pulses done, clears running.
- Terminal, wrap_en = 1: tick from all-max (up) to all-zero, or all-zero (down) to all-max, pulses done; running stays 1.
- dir and wrap_en are sampled at each tick; changes mid-run take effect on the next tick.
- lap_capture: lap_value <= count as held before this edge's update.

## Timing
- Count, running, done, lap_value are registered; all control inputs act on the same edge.
- First tick after start from prescaler 0 lands TICK_DIV edges after the start edge; TICK_DIV = 1 steps every running cycle.
- done high exactly one cycle, coincident with the count update that caused it.
- rst_n assertion mid-run forces reset values immediately, independent of clk; deassertion is synchronised externally.
- Prescaler width $clog2(TICK_DIV), minimum 1 bit; no combinational path from inputs to outputs.

## Configuration
- LAP_CAPTURE_EN defined: lap register and lap_capture behaviour as above.
- Not defined: lap_value tied to 0, lap_capture ignored, no lap register synthesised.

## Test plan
(DIGITS=4, default DIGIT_MOD, TICK_DIV=4.)
- ld 0x5958, dir 0, wrap_en 0, start -> 4 edges later count 0x5959, done 1 cycle, running 0; further start ignored.
- ld 0x0001, dir 1, wrap_en 0, start -> count 0x0000 after 4 edges, done, running 0; ld 0x0100 then start -> next tick 0x0059.
- ld 0x5959, dir 0, wrap_en 1, start -> 0x0000, done, running stays 1; switch dir 1 from 0x0000 -> 0x5959 with done.
- ld 0xA7F3 -> count 0x0703; start+stop same edge -> running 0.
- start, stop after 2 edges, idle 10, start -> tick 2 edges later (prescaler retained); clr while running -> 0x0000, running 1.
- LAP_CAPTURE_EN: lap_capture at count 0x0012 on a tick edge -> lap_value 0x0012, count 0x0013; rst_n low mid-run -> all outputs 0 before next clk.
